// File: rtl/temperature_alert_fsm.sv
// temperature_alert_fsm: debounced over/under-temperature alarm with caregiver
// acknowledge, a recovery window before the alarm clears, and an episode counter.
module temperature_alert_fsm #(
   parameter int CONFIRM_COUNT = 4,   // consecutive same-type abnormal samples to alarm
   parameter int CLEAR_COUNT   = 8    // consecutive normal samples to clear
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sample_valid,
   input  logic       temp_high,
   input  logic       temp_low,
   input  logic       alarm_ack,
   output logic       alarm,
   output logic [1:0] alarm_type,
   output logic       alarm_pending,
   output logic [7:0] event_count
);

   typedef enum logic [1:0] {S_IDLE, S_CONFIRM, S_ALARM, S_RECOVER} state_t;

   localparam logic [1:0] T_NONE = 2'b00;
   localparam logic [1:0] T_LOW  = 2'b01;
   localparam logic [1:0] T_HIGH = 2'b10;
   localparam logic [3:0] CONF_N  = 4'(CONFIRM_COUNT);
   localparam logic [3:0] CLEAR_N = 4'(CLEAR_COUNT);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [1:0] cand_q, cand_d;        // candidate type while confirming
   logic       ack_seen_q, ack_seen_d;
   logic       alarm_q, alarm_d;
   logic [1:0] alarm_type_q, alarm_type_d;
   logic       pending_q, pending_d;
   logic [7:0] event_count_q, event_count_d;
   logic [1:0] smp_type;

   // high wins when both flags are set
   assign smp_type = temp_high ? T_HIGH : (temp_low ? T_LOW : T_NONE);

   // state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         cand_q        <= T_NONE;
         ack_seen_q    <= 1'b0;
         alarm_q       <= 1'b0;
         alarm_type_q  <= T_NONE;
         pending_q     <= 1'b0;
         event_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cand_q        <= cand_d;
         ack_seen_q    <= ack_seen_d;
         alarm_q       <= alarm_d;
         alarm_type_q  <= alarm_type_d;
         pending_q     <= pending_d;
         event_count_q <= event_count_d;
      end
   end

   // next-state and output computation; only valid samples move the FSM
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      cand_d        = cand_q;
      ack_seen_d    = ack_seen_q;
      alarm_type_d  = alarm_type_q;
      event_count_d = event_count_q;

      // ack is only meaningful while the alarm is unacknowledged-in-ALARM
      if (state_q == S_ALARM && alarm_ack)
         ack_seen_d = 1'b1;

      if (sample_valid) begin
         unique case (state_q)
            S_IDLE: begin
               if (smp_type != T_NONE) begin
                  state_d = S_CONFIRM;
                  cand_d  = smp_type;
                  cnt_d   = 4'd1;
               end
            end
            S_CONFIRM: begin
               if (smp_type == T_NONE) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
                  cand_d  = T_NONE;
               end else if (smp_type == cand_q) begin
                  if (cnt_q + 4'd1 == CONF_N) begin
                     state_d       = S_ALARM;
                     cnt_d         = '0;
                     alarm_type_d  = cand_q;
                     ack_seen_d    = 1'b0;
                     event_count_d = (event_count_q == 8'hFF) ? 8'hFF : event_count_q + 8'd1;
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end else begin
                  // opposite abnormal type restarts confirmation
                  cand_d = smp_type;
                  cnt_d  = 4'd1;
               end
            end
            S_ALARM: begin
               if (smp_type == T_NONE) begin
                  if (ack_seen_q || alarm_ack) begin
                     // this normal sample is the first of the clear window
                     if (CLEAR_N == 4'd1) begin
                        state_d      = S_IDLE;
                        cnt_d        = '0;
                        cand_d       = T_NONE;
                        alarm_type_d = T_NONE;
                        ack_seen_d   = 1'b0;
                     end else begin
                        state_d = S_RECOVER;
                        cnt_d   = 4'd1;
                     end
                  end
               end else if (smp_type != alarm_type_q) begin
                  alarm_type_d = smp_type;
                  ack_seen_d   = 1'b0;
               end
            end
            S_RECOVER: begin
               if (smp_type == T_NONE) begin
                  if (cnt_q + 4'd1 == CLEAR_N) begin
                     state_d      = S_IDLE;
                     cnt_d        = '0;
                     cand_d       = T_NONE;
                     alarm_type_d = T_NONE;
                     ack_seen_d   = 1'b0;
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end else begin
                  // relapse: same episode, fresh ack needed
                  state_d      = S_ALARM;
                  cnt_d        = '0;
                  alarm_type_d = smp_type;
                  ack_seen_d   = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      alarm_d   = (state_d == S_ALARM) || (state_d == S_RECOVER);
      pending_d = (state_d == S_CONFIRM);
   end

   assign alarm         = alarm_q;
   assign alarm_type    = alarm_type_q;
   assign alarm_pending = pending_q;
   assign event_count   = event_count_q;

endmodule

// File: tb/tb_temperature_alert_fsm.sv
// Directed testbench for temperature_alert_fsm with hand-computed expectations.
module tb_temperature_alert_fsm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sample_valid = 1'b0;
   logic       temp_high = 1'b0;
   logic       temp_low = 1'b0;
   logic       alarm_ack = 1'b0;
   logic       alarm;
   logic [1:0] alarm_type;
   logic       alarm_pending;
   logic [7:0] event_count;

   int n_chk  = 0;
   int n_fail = 0;

   temperature_alert_fsm #(.CONFIRM_COUNT(4), .CLEAR_COUNT(8)) dut (
      .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
      .temp_high(temp_high), .temp_low(temp_low), .alarm_ack(alarm_ack),
      .alarm(alarm), .alarm_type(alarm_type), .alarm_pending(alarm_pending),
      .event_count(event_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // one valid sample (optionally with ack), outputs settle 1ns after the edge
   task automatic smp(input logic h, input logic l, input logic a);
      @(negedge clk);
      sample_valid = 1'b1; temp_high = h; temp_low = l; alarm_ack = a;
      @(posedge clk); #1;
      sample_valid = 1'b0; temp_high = 1'b0; temp_low = 1'b0; alarm_ack = 1'b0;
   endtask

   // ack pulse on a cycle with no sample
   task automatic ack_only();
      @(negedge clk);
      alarm_ack = 1'b1;
      @(posedge clk); #1;
      alarm_ack = 1'b0;
   endtask

   // ack together with the first normal sample, then finish the clear window
   task automatic clear_alarm();
      smp(0, 0, 1);
      repeat (7) smp(0, 0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #12;
      check("rst_alarm",   {7'd0, alarm}, 8'd0);
      check("rst_type",    {6'd0, alarm_type}, 8'd0);
      check("rst_pending", {7'd0, alarm_pending}, 8'd0);
      check("rst_events",  event_count, 8'd0);
      @(negedge clk); rst_n = 1'b1;

      // ack in IDLE must be ignored
      ack_only();
      check("idle_ack_alarm", {7'd0, alarm}, 8'd0);

      // four HIGH samples raise the alarm
      smp(1, 0, 0);
      check("h1_pending", {7'd0, alarm_pending}, 8'd1);
      check("h1_alarm",   {7'd0, alarm}, 8'd0);
      smp(1, 0, 0); smp(1, 0, 0);
      check("h3_alarm",   {7'd0, alarm}, 8'd0);
      smp(1, 0, 0);
      check("h4_alarm",   {7'd0, alarm}, 8'd1);
      check("h4_type",    {6'd0, alarm_type}, 8'd2);
      check("h4_pending", {7'd0, alarm_pending}, 8'd0);
      check("h4_events",  event_count, 8'd1);
      smp(0, 0, 1);
      repeat (6) smp(0, 0, 0);
      check("clr7_alarm", {7'd0, alarm}, 8'd1);
      smp(0, 0, 0);
      check("clr8_alarm", {7'd0, alarm}, 8'd0);
      check("clr8_type",  {6'd0, alarm_type}, 8'd0);

      // NORMAL during confirmation aborts it
      smp(1, 0, 0); smp(0, 0, 0);
      check("abort_pending", {7'd0, alarm_pending}, 8'd0);

      // LOW, LOW, then HIGH restarts the count
      smp(0, 1, 0); smp(0, 1, 0);
      check("ll_alarm",   {7'd0, alarm}, 8'd0);
      check("ll_pending", {7'd0, alarm_pending}, 8'd1);
      smp(1, 0, 0); smp(1, 0, 0); smp(1, 0, 0);
      check("llhhh_alarm", {7'd0, alarm}, 8'd0);
      smp(1, 0, 0);
      check("llhhhh_alarm",  {7'd0, alarm}, 8'd1);
      check("llhhhh_type",   {6'd0, alarm_type}, 8'd2);
      check("llhhhh_events", event_count, 8'd2);

      // no ack: ten normals keep the alarm
      repeat (10) smp(0, 0, 0);
      check("noack_alarm", {7'd0, alarm}, 8'd1);
      ack_only();
      repeat (7) smp(0, 0, 0);
      check("ack7_alarm", {7'd0, alarm}, 8'd1);
      smp(0, 0, 0);
      check("ack8_alarm", {7'd0, alarm}, 8'd0);
      check("ack8_type",  {6'd0, alarm_type}, 8'd0);

      // relapse from RECOVER: LOW returns to ALARM, no new event, ack re-required
      repeat (4) smp(1, 0, 0);
      check("ep3_events", event_count, 8'd3);
      smp(0, 0, 1);
      repeat (4) smp(0, 0, 0);
      smp(0, 1, 0);
      check("relapse_alarm",  {7'd0, alarm}, 8'd1);
      check("relapse_type",   {6'd0, alarm_type}, 8'd1);
      check("relapse_events", event_count, 8'd3);
      repeat (8) smp(0, 0, 0);
      check("relapse_noack_alarm", {7'd0, alarm}, 8'd1);

      // type change in ALARM clears an earlier ack
      ack_only();
      smp(1, 0, 0);
      check("retype_type", {6'd0, alarm_type}, 8'd2);
      repeat (8) smp(0, 0, 0);
      check("retype_alarm", {7'd0, alarm}, 8'd1);
      clear_alarm();
      check("retype_clr_alarm", {7'd0, alarm}, 8'd0);

      // both flags set count as HIGH
      repeat (4) smp(1, 1, 0);
      check("both_type",   {6'd0, alarm_type}, 8'd2);
      check("both_events", event_count, 8'd4);

      // asynchronous reset while alarm is up
      @(negedge clk); #2;
      rst_n = 1'b0; #1;
      check("async_alarm",   {7'd0, alarm}, 8'd0);
      check("async_type",    {6'd0, alarm_type}, 8'd0);
      check("async_pending", {7'd0, alarm_pending}, 8'd0);
      check("async_events",  event_count, 8'd0);
      @(negedge clk); rst_n = 1'b1;

      // reset mid-CONFIRM discards the partial count
      smp(1, 0, 0); smp(1, 0, 0);
      do_reset();
      repeat (3) smp(1, 0, 0);
      check("midrst_alarm",   {7'd0, alarm}, 8'd0);
      check("midrst_pending", {7'd0, alarm_pending}, 8'd1);
      smp(1, 0, 0);
      check("midrst_alarm4", {7'd0, alarm}, 8'd1);
      check("midrst_events", event_count, 8'd1);

      // saturation over 300 episodes
      do_reset();
      for (int ep = 1; ep <= 300; ep++) begin
         repeat (4) smp(1, 0, 0);
         clear_alarm();
         if (ep == 254) check("sat_254", event_count, 8'd254);
         if (ep == 255) check("sat_255", event_count, 8'd255);
         if (ep == 256) check("sat_256", event_count, 8'd255);
      end
      check("sat_300", event_count, 8'd255);
      check("sat_alarm", {7'd0, alarm}, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
